// File: rtl/my_pc_ctrl_pkg.sv
// rtl/my_pc_ctrl_pkg.sv - shared state codes and instruction field positions for the PC sequencer
package my_pc_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_RST   = 3'd0;
  localparam state_t ST_IDLE  = 3'd1;
  localparam state_t ST_FETCH = 3'd2;
  localparam state_t ST_EXEC  = 3'd3;
  localparam state_t ST_HALT  = 3'd4;

  localparam int C_BIT = 15;
  localparam int J_HI  = 2;
  localparam int J_LO  = 0;

  localparam logic [2:0] JMP_ALL = 3'b111;

  // Unconditional-jump compute instruction; combined with a self-target it means halt.
  function automatic logic is_jmp_all(input logic c_bit, input logic [2:0] j_bits);
    return c_bit && (j_bits == JMP_ALL);
  endfunction

endpackage

// File: rtl/my_pc_ctrl_if.sv
// rtl/my_pc_ctrl_if.sv - bundle of the fetch handshake and PC control signals
interface my_pc_ctrl_if;
  import my_pc_ctrl_pkg::*;

  logic        run;
  logic [15:0] instr;
  logic        imem_ack;
  logic [15:0] a_reg;
  logic [15:0] pc;
  logic        zr;
  logic        ng;
  logic        imem_req;
  logic        pc_load;
  logic        pc_inc;
  logic        pc_reset;
  logic [15:0] pc_in;
  logic        exec_en;
  logic        halted;
  logic [15:0] retired;

  modport master (
    input  run, instr, imem_ack, a_reg, pc, zr, ng,
    output imem_req, pc_load, pc_inc, pc_reset, pc_in, exec_en, halted, retired
  );

  modport slave (
    output run, instr, imem_ack, a_reg, pc, zr, ng,
    input  imem_req, pc_load, pc_inc, pc_reset, pc_in, exec_en, halted, retired
  );

endinterface

// File: rtl/my_jump_cond.sv
// rtl/my_jump_cond.sv - jump decision from the latched C-bit, J-bits and ALU flags
module my_jump_cond
  import my_pc_ctrl_pkg::*;
(
  input  logic       c_bit_i,
  input  logic [2:0] j_bits_i,
  input  logic       zr_i,
  input  logic       ng_i,
  output logic       jump_o
);

  // J-bits select lt / eq / gt; A-instructions (C-bit clear) never jump.
  assign jump_o = c_bit_i & ((j_bits_i[J_HI]     & ng_i) |
                             (j_bits_i[J_LO + 1] & zr_i) |
                             (j_bits_i[J_LO]     & ~ng_i & ~zr_i));

endmodule

// File: rtl/my_pc_ctrl.sv
// rtl/my_pc_ctrl.sv - fetch/execute sequencer driving the program counter controls
module my_pc_ctrl
  import my_pc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] instr,
  input  logic        imem_ack,
  input  logic [15:0] a_reg,
  input  logic [15:0] pc,
  input  logic        zr,
  input  logic        ng,
  output logic        imem_req,
  output logic        pc_load,
  output logic        pc_inc,
  output logic        pc_reset,
  output logic [15:0] pc_in,
  output logic        exec_en,
  output logic        halted,
  output logic [15:0] retired
);

  state_t      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] retired_q, retired_d;
  logic        run_q;
  logic        jump;
  logic        halt_hit;
  logic        unused_instr_bits;

  my_jump_cond u_jump_cond (
    .c_bit_i  (instr_q[C_BIT]),
    .j_bits_i (instr_q[J_HI:J_LO]),
    .zr_i     (zr),
    .ng_i     (ng),
    .jump_o   (jump)
  );

  assign halt_hit          = is_jmp_all(instr_q[C_BIT], instr_q[J_HI:J_LO]) && (a_reg == pc);
  assign unused_instr_bits = ^instr_q[C_BIT-1:J_HI+1];
  assign retired           = retired_q;

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      ST_RST:   state_d = ST_IDLE;
      ST_IDLE:  if (run) state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d = instr;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        retired_d = retired_q + 16'd1;
        if (halt_hit)  state_d = ST_HALT;
        else if (run)  state_d = ST_FETCH;
        else           state_d = ST_IDLE;
      end
      // Leaving HALT needs a fresh 0->1 on run, not just a held level.
      ST_HALT:  if (run && !run_q) state_d = ST_IDLE;
      default:  state_d = ST_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_RST;
      instr_q   <= '0;
      retired_q <= '0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      run_q     <= run;
    end
  end

  always_comb begin
    imem_req = 1'b0;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_reset = 1'b0;
    pc_in    = '0;
    exec_en  = 1'b0;
    halted   = 1'b0;
    case (state_q)
      ST_RST:   pc_reset = 1'b1;
      ST_FETCH: imem_req = 1'b1;
      ST_EXEC: begin
        exec_en = 1'b1;
        pc_load = jump;
        pc_inc  = ~jump;
        pc_in   = jump ? a_reg : 16'h0000;
      end
      ST_HALT:  halted = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_my_pc_ctrl.sv
// tb/tb_my_pc_ctrl.sv - directed self-checking bench for my_pc_ctrl
`timescale 1ns/1ps
module tb_my_pc_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   exec_seen = 0;

  my_pc_ctrl_if bus ();

  my_pc_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .run      (bus.run),
    .instr    (bus.instr),
    .imem_ack (bus.imem_ack),
    .a_reg    (bus.a_reg),
    .pc       (bus.pc),
    .zr       (bus.zr),
    .ng       (bus.ng),
    .imem_req (bus.imem_req),
    .pc_load  (bus.pc_load),
    .pc_inc   (bus.pc_inc),
    .pc_reset (bus.pc_reset),
    .pc_in    (bus.pc_in),
    .exec_en  (bus.exec_en),
    .halted   (bus.halted),
    .retired  (bus.retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  // Control vector order: imem_req, pc_load, pc_inc, pc_reset, exec_en, halted
  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    chk(tag, {10'd0, bus.imem_req, bus.pc_load, bus.pc_inc, bus.pc_reset, bus.exec_en, bus.halted},
        {10'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    bus.run = 1'b0;
    bus.instr = 16'h0000;
    bus.imem_ack = 1'b0;
    bus.a_reg = 16'h0000;
    bus.pc = 16'h0000;
    bus.zr = 1'b0;
    bus.ng = 1'b0;

    // Reset held two cycles
    tick();
    chk_ctl("rst_ctl_1", 6'b000100);
    chk("rst_pc_in", bus.pc_in, 16'h0000);
    tick();
    chk_ctl("rst_ctl_2", 6'b000100);
    reset = 1'b1;
    tick();
    chk_ctl("idle_ctl", 6'b000000);
    chk("idle_retired", bus.retired, 16'h0000);
    tick();
    chk_ctl("idle_hold", 6'b000000);

    // Sequential A-instruction with two wait cycles
    bus.run = 1'b1;
    bus.instr = 16'h0005;
    tick();
    chk_ctl("fetch_wait1", 6'b100000);
    tick();
    chk_ctl("fetch_wait2", 6'b100000);
    bus.imem_ack = 1'b1;
    #1;
    chk_ctl("fetch_ack", 6'b100000);
    tick();
    bus.imem_ack = 1'b0;
    bus.instr = 16'hFFFF;
    #1;
    chk_ctl("seq_exec", 6'b001010);
    tick();
    chk("seq_retired", bus.retired, 16'h0001);
    chk_ctl("seq_refetch", 6'b100000);

    // JEQ taken, then flag drop inside EXEC
    bus.instr = 16'hE302; bus.zr = 1'b1; bus.ng = 1'b0; bus.a_reg = 16'h0040; bus.imem_ack = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    #1;
    chk_ctl("jeq_taken", 6'b010010);
    chk("jeq_pc_in", bus.pc_in, 16'h0040);
    bus.zr = 1'b0;
    #1;
    chk_ctl("jeq_flag_drop", 6'b001010);
    chk("jeq_pc_in_zero", bus.pc_in, 16'h0000);
    tick();

    // JGT not taken with ng=1
    bus.instr = 16'hE301; bus.ng = 1'b1; bus.zr = 1'b0; bus.imem_ack = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    #1;
    chk_ctl("jgt_not_taken", 6'b001010);
    chk("jgt_pc_in", bus.pc_in, 16'h0000);
    tick();

    // JLT taken via ng
    bus.instr = 16'h8004; bus.ng = 1'b1; bus.a_reg = 16'h1234; bus.imem_ack = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    #1;
    chk_ctl("jlt_taken", 6'b010010);
    chk("jlt_pc_in", bus.pc_in, 16'h1234);
    tick();

    // A-instruction with low bits 111 and self target: neither jump nor halt
    bus.instr = 16'h0007; bus.ng = 1'b0; bus.a_reg = 16'h0010; bus.pc = 16'h0010; bus.imem_ack = 1'b1;
    tick();
    chk_ctl("a_instr_no_jump", 6'b001010);
    tick();
    chk_ctl("a_instr_no_halt", 6'b100000);

    // Halt on 0;JMP to itself
    bus.instr = 16'hEA87;
    tick();
    bus.imem_ack = 1'b0;
    #1;
    chk_ctl("halt_exec_load", 6'b010010);
    chk("halt_pc_in", bus.pc_in, 16'h0010);
    tick();
    chk_ctl("halted", 6'b000001);
    chk("halt_retired", bus.retired, 16'h0006);
    tick();
    chk_ctl("halt_run_level", 6'b000001);
    bus.run = 1'b0;
    tick();
    chk_ctl("halt_run_low", 6'b000001);
    bus.run = 1'b1;
    tick();
    chk_ctl("halt_exit_idle", 6'b000000);
    tick();
    chk_ctl("halt_refetch", 6'b100000);

    // Retired counter wrap: 6 executed so far, 65530 more reach zero
    bus.instr = 16'h0000; bus.imem_ack = 1'b1;
    for (int i = 0; i < 65529; i++) begin
      tick();
      if (bus.exec_en === 1'b1) exec_seen++;
      tick();
    end
    chk("retired_ffff", bus.retired, 16'hFFFF);
    tick();
    if (bus.exec_en === 1'b1) exec_seen++;
    tick();
    chk("retired_wrap", bus.retired, 16'h0000);
    chk("exec_pulses", exec_seen[15:0], 16'hFFFA);
    tick();
    tick();
    chk("retired_after_wrap", bus.retired, 16'h0001);

    // Reset in FETCH overrides run and imem_ack
    reset = 1'b0;
    #1;
    chk_ctl("pre_reset_fetch", 6'b100000);
    tick();
    chk_ctl("fetch_reset_ctl", 6'b000100);
    chk("fetch_reset_retired", bus.retired, 16'h0000);

    // Reset in EXEC suppresses the count and PC update
    reset = 1'b1;
    bus.imem_ack = 1'b0;
    tick();
    tick();
    bus.imem_ack = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    #1;
    chk_ctl("exec_before_reset", 6'b001010);
    reset = 1'b0;
    tick();
    chk_ctl("exec_reset_ctl", 6'b000100);
    chk("exec_reset_retired", bus.retired, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
